// File: rtl/tuner_pkg.sv
// Shared types and defaults for the tuner datapath blocks.
// Provides the lock FSM state encoding and the default sample width.
package tuner_pkg;

    localparam int WIDTH_DEF = 24;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/range_lock_detector_if.sv
// Bus between the frequency estimator side and range_lock_detector.
// Signals: cfg_load/cfg_target/cfg_tol, in_valid/x in; out_valid/in_range/locked out.
// RANGE_DIR_EN adds sharp/flat outputs.
interface range_lock_detector_if
    import tuner_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic                    cfg_load;
    logic signed [WIDTH-1:0] cfg_target;
    logic signed [WIDTH-1:0] cfg_tol;
    logic                    in_valid;
    logic signed [WIDTH-1:0] x;
    logic                    out_valid;
    logic                    in_range;
    logic                    locked;
`ifdef RANGE_DIR_EN
    logic                    sharp;
    logic                    flat;
`endif

`ifdef RANGE_DIR_EN
    modport master (
        output cfg_load, cfg_target, cfg_tol, in_valid, x,
        input  out_valid, in_range, locked, sharp, flat
    );

    modport slave (
        input  cfg_load, cfg_target, cfg_tol, in_valid, x,
        output out_valid, in_range, locked, sharp, flat
    );
`else
    modport master (
        output cfg_load, cfg_target, cfg_tol, in_valid, x,
        input  out_valid, in_range, locked
    );

    modport slave (
        input  cfg_load, cfg_target, cfg_tol, in_valid, x,
        output out_valid, in_range, locked
    );
`endif

endinterface

// File: rtl/range_lock_detector_window.sv
// range_window: combinational inclusive window test of x against target +/- tol.
// Ports: x, target, tol in; hit (in window), above (x>upper), below (x<lower) out.
module range_window
    import tuner_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] target,
    input  logic signed [WIDTH-1:0] tol,
    output logic                    hit,
    output logic                    above,
    output logic                    below
);

    localparam int EW = WIDTH + 1;

    logic signed [EW-1:0] x_e;
    logic signed [EW-1:0] t_e;
    logic signed [EW-1:0] tol_e;
    logic signed [EW-1:0] upper;
    logic signed [EW-1:0] lower;

    // One extra bit holds any sum/difference of two WIDTH-bit values.
    assign x_e   = {x[WIDTH-1], x};
    assign t_e   = {target[WIDTH-1], target};
    assign tol_e = {tol[WIDTH-1], tol};

    assign upper = t_e + tol_e;
    assign lower = t_e - tol_e;

    assign above = (x_e > upper);
    assign below = (x_e < lower);

    // A negative tolerance describes an empty window.
    assign hit = ~tol[WIDTH-1] & (x_e >= lower) & (x_e <= upper);

endmodule

// File: rtl/range_lock_detector.sv
// range_lock_detector: registered window comparator with lock/unlock debouncing.
// Ports: clock, resetn (sync, active-low), bus (slave: cfg, sample in; flags out).
// Optional RANGE_DIR_EN macro adds registered sharp/flat direction flags.
module range_lock_detector
    import tuner_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    range_lock_detector_if.slave bus
);

    localparam logic [CNT_W-1:0] RUN_MAX  = '1;
    localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_CNT);

    logic signed [WIDTH-1:0] target_q;
    logic signed [WIDTH-1:0] tol_q;

    lock_state_t      state_q;
    lock_state_t      state_d;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;
    logic [CNT_W-1:0] run_inc;

    logic out_valid_q;
    logic in_range_q;
    logic hit;
    logic sample;

    // A sample coinciding with cfg_load is dropped.
    assign sample = bus.in_valid & ~bus.cfg_load;

`ifdef RANGE_DIR_EN
    logic above;
    logic below;
    logic sharp_q;
    logic flat_q;

    range_window #(
        .WIDTH (WIDTH)
    ) u_window (
        .x      (bus.x),
        .target (target_q),
        .tol    (tol_q),
        .hit    (hit),
        .above  (above),
        .below  (below)
    );
`else
    range_window #(
        .WIDTH (WIDTH)
    ) u_window (
        .x      (bus.x),
        .target (target_q),
        .tol    (tol_q),
        .hit    (hit),
        .above  (),
        .below  ()
    );
`endif

    assign run_inc = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= UNLOCKED;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (bus.cfg_load) begin
            state_d = UNLOCKED;
            run_d   = '0;
        end else if (bus.in_valid) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (!hit) begin
                        run_d = '0;
                    end else if (run_inc == LOCK_C) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        run_d = '0;
                    end else if (run_inc == UNLOCK_C) begin
                        state_d = UNLOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            target_q    <= '0;
            tol_q       <= '0;
            out_valid_q <= 1'b0;
            in_range_q  <= 1'b0;
        end else begin
            out_valid_q <= sample;
            if (bus.cfg_load) begin
                target_q <= bus.cfg_target;
                tol_q    <= bus.cfg_tol;
            end
            if (sample) begin
                in_range_q <= hit;
            end
        end
    end

`ifdef RANGE_DIR_EN
    // With an empty window both raw flags can be set; sharp wins.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sharp_q <= 1'b0;
            flat_q  <= 1'b0;
        end else if (sample) begin
            sharp_q <= above;
            flat_q  <= below & ~above;
        end
    end

    assign bus.sharp = sharp_q;
    assign bus.flat  = flat_q;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.in_range  = in_range_q;
    assign bus.locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_range_lock_detector.sv
// Scoreboard bench for range_lock_detector.
// Directed samples push expected flags; a negedge monitor pops and compares.
module tb_range_lock_detector;

    import tuner_pkg::*;

    typedef struct {
        logic r;
        logic l;
        int   id;
    } exp_t;

    logic clock = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    int   n_id   = 0;
    exp_t q[$];

    always #5 clock = ~clock;

    range_lock_detector_if #(.WIDTH(24)) bus ();

    range_lock_detector #(
        .WIDTH      (24),
        .LOCK_CNT   (8),
        .UNLOCK_CNT (4),
        .CNT_W      (4)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic chk(string name, int idx, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %0b expected %0b", name, idx, act, exp);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (resetn === 1'b1 && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
                e = q.pop_front();
                chk("in_range", e.id, bus.in_range, e.r);
                chk("locked", e.id, bus.locked, e.l);
            end
        end
    end

    task automatic send(logic [23:0] v, logic r, logic l);
        exp_t e;
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.x = v;
        e.r = r;
        e.l = l;
        e.id = n_id;
        n_id++;
        q.push_back(e);
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(logic [23:0] t, logic [23:0] tl);
        @(negedge clock);
        bus.cfg_load = 1'b1;
        bus.cfg_target = t;
        bus.cfg_tol = tl;
        @(negedge clock);
        bus.cfg_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        bus.cfg_load = 1'b0;
        bus.cfg_target = '0;
        bus.cfg_tol = '0;
        bus.in_valid = 1'b0;
        bus.x = '0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", 0, bus.out_valid, 1'b0);
        chk("rst_in_range", 0, bus.in_range, 1'b0);
        chk("rst_locked", 0, bus.locked, 1'b0);
        resetn = 1'b1;

        // Inclusive bounds of 100 +/- 5
        load(24'd100, 24'd5);
        send(24'd105, 1'b1, 1'b0);
        send(24'd95, 1'b1, 1'b0);
        send(24'd106, 1'b0, 1'b0);
        send(24'd94, 1'b0, 1'b0);

        // Miss at the 7th sample restarts the lock count
        for (int i = 0; i < 6; i++) send(24'd100, 1'b1, 1'b0);
        send(24'd90, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(24'd100, 1'b1, 1'b0);
        send(24'd100, 1'b1, 1'b1);

        // Unlock: 3 misses, 1 hit, then 4 misses
        for (int i = 0; i < 3; i++) send(24'd200, 1'b0, 1'b1);
        send(24'd101, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(24'd200, 1'b0, 1'b1);
        send(24'd200, 1'b0, 1'b0);

        // Window near the positive limit, no overflow
        load(24'h7FFFF0, 24'd32);
        send(24'h7FFFFF, 1'b1, 1'b0);
        send(24'h800000, 1'b0, 1'b0);
        send(24'h7FFFD0, 1'b1, 1'b0);
        send(24'h7FFFCF, 1'b0, 1'b0);

        // Negative tolerance: empty window
        load(24'd100, 24'hFFFFFF);
        send(24'd100, 1'b0, 1'b0);

        // cfg_load with a simultaneous sample while locked
        load(24'd100, 24'd5);
        for (int i = 0; i < 7; i++) send(24'd100, 1'b1, 1'b0);
        send(24'd100, 1'b1, 1'b1);
        @(negedge clock);
        bus.cfg_load = 1'b1;
        bus.cfg_target = 24'd100;
        bus.cfg_tol = 24'd5;
        bus.in_valid = 1'b1;
        bus.x = 24'd100;
        @(negedge clock);
        chk("load_drop_out_valid", 0, bus.out_valid, 1'b0);
        chk("load_locked", 0, bus.locked, 1'b0);
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) send(24'd100, 1'b1, 1'b0);
        send(24'd100, 1'b1, 1'b1);

        // Reset mid-lock clears outputs and config
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        chk("mid_rst_out_valid", 0, bus.out_valid, 1'b0);
        chk("mid_rst_in_range", 0, bus.in_range, 1'b0);
        chk("mid_rst_locked", 0, bus.locked, 1'b0);
        resetn = 1'b1;
        send(24'd0, 1'b1, 1'b0);
        send(24'd100, 1'b0, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);

`ifdef RANGE_DIR_EN
        load(24'd100, 24'd5);
        send(24'd106, 1'b0, 1'b0);
        chk("sharp_hi", 0, bus.sharp, 1'b1);
        chk("flat_hi", 0, bus.flat, 1'b0);
        send(24'd94, 1'b0, 1'b0);
        chk("sharp_lo", 0, bus.sharp, 1'b0);
        chk("flat_lo", 0, bus.flat, 1'b1);
        send(24'd100, 1'b1, 1'b0);
        chk("sharp_mid", 0, bus.sharp, 1'b0);
        chk("flat_mid", 0, bus.flat, 1'b0);
`endif

        repeat (3) @(negedge clock);
        chk("queue_drained", q.size(), (q.size() == 0), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
